// File: rtl/lm07_responder.sv
// rtl/lm07_responder.sv - LM07 3-wire temperature sensor emulator (SPI slave, SYSCLK oversampled)
module lm07_responder #(
    parameter int          SYNC_STAGES  = 2,
    parameter logic [15:0] CMD_SHUTDOWN = 16'hFFFF,
    parameter logic [15:0] CMD_NORMAL   = 16'h0000
) (
    input  logic        SYSCLK,
    input  logic        RST,
    input  logic        CS,
    input  logic        SCK,
    input  logic        sio_in,
    output logic        sio_out,
    output logic        sio_oe,
    input  logic [12:0] temp_in,
    output logic        shutdown,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, sio_sync_q;
    logic                   cs_prev_q, sck_prev_q;
    logic [12:0]            snap_q, snap_d;
    logic [15:0]            tx_q, tx_d;
    logic [15:0]            cmd_q, cmd_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic                   shutdown_q, shutdown_d;
    logic                   done_q, done_d;

    logic cs_s, sck_s, sio_s;
    logic cs_fall, cs_rise, sck_rise, sck_fall;

    assign cs_s  = cs_sync_q[SYNC_STAGES-1];
    assign sck_s = sck_sync_q[SYNC_STAGES-1];
    assign sio_s = sio_sync_q[SYNC_STAGES-1];

    // CS chain resets low so a CS already low at reset release never looks like a fall.
    assign cs_fall  =  cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q &  cs_s;
    assign sck_rise = ~sck_prev_q &  sck_s & ~cs_fall;
    assign sck_fall =  sck_prev_q & ~sck_s & ~cs_fall;

    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            cs_sync_q  <= '0;
            sck_sync_q <= '0;
            sio_sync_q <= '0;
            cs_prev_q  <= 1'b0;
            sck_prev_q <= 1'b0;
            snap_q     <= '0;
            tx_q       <= '0;
            cmd_q      <= '0;
            bit_cnt_q  <= '0;
            shutdown_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
            sio_sync_q <= {sio_sync_q[SYNC_STAGES-2:0], sio_in};
            cs_prev_q  <= cs_s;
            sck_prev_q <= sck_s;
            snap_q     <= snap_d;
            tx_q       <= tx_d;
            cmd_q      <= cmd_d;
            bit_cnt_q  <= bit_cnt_d;
            shutdown_q <= shutdown_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        tx_d       = tx_q;
        cmd_d      = cmd_q;
        bit_cnt_d  = bit_cnt_q;
        shutdown_d = shutdown_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    snap_d    = shutdown_q ? snap_q : temp_in;
                    tx_d      = {snap_d, 3'b111};
                    cmd_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = READ;
                end
            end
            READ: begin
                if (cs_rise) begin
                    bit_cnt_d = '0;
                    cmd_d     = '0;
                    state_d   = IDLE;
                end else if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end else if (sck_fall) begin
                    if (bit_cnt_q == 5'd16) begin
                        bit_cnt_d = '0;
                        state_d   = WRITE;
                    end else begin
                        tx_d = {tx_q[14:0], 1'b1};
                    end
                end
            end
            WRITE: begin
                if (cs_rise) begin
                    bit_cnt_d = '0;
                    cmd_d     = '0;
                    state_d   = IDLE;
                end else if (sck_rise) begin
                    cmd_d     = {cmd_q[14:0], sio_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd15) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    if (cmd_q == CMD_SHUTDOWN) begin
                        shutdown_d = 1'b1;
                    end else if (cmd_q == CMD_NORMAL) begin
                        shutdown_d = 1'b0;
                    end
                    done_d    = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pad drive follows state directly so RST releases SIO without waiting for a clock.
    always_comb begin
        sio_oe     = (state_q == READ);
        sio_out    = (state_q == READ) ? tx_q[15] : 1'b1;
        busy       = (state_q != IDLE);
        shutdown   = shutdown_q;
        frame_done = done_q;
    end

endmodule
